// File: rtl/lynxTypes.sv
// Shared RDMA definitions used by the send-queue arbiter and the queue logic
// on the network side, so that both agree on the ack word format and the
// per-requester credit depth.
//   RDMA_ACK_ID_LSB : bit position of the requester-id field in an ack word
//   RDMA_N_CREDITS  : default maximum outstanding commands per requester
//   id_width()      : bits needed to hold a requester index (minimum 1)
package lynxTypes;

  localparam int RDMA_ACK_ID_LSB = 0;
  localparam int RDMA_N_CREDITS  = 16;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rdma_rr_pick.sv
// Combinational round-robin picker. It returns the first requesting index
// at or after ptr, wrapping modulo N. It is reusable by any shared queue.
//   req   in  N    request vector
//   ptr   in  IDW  index with the highest priority this cycle (< N)
//   grant out N    one-hot grant, zero when nothing requests
//   idx   out IDW  binary index of the grant
//   any   out 1    some index was granted
module rdma_rr_pick
  import lynxTypes::*;
#(
  parameter  int N   = 4,
  localparam int IDW = id_width(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           any
);

  // NOTE: every output gets a default before the search loops. Without the
  // defaults, a path that leaves an output unassigned would infer a latch.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    // First pass: search from ptr up to the top index.
    for (int i = 0; i < N; i++) begin
      if (!any && req[i] && (IDW'(i) >= ptr)) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        idx      = IDW'(i);
      end
    end
    // Second pass: wrap around. The first pass found nothing at or above
    // ptr, so the lowest requesting index wins.
    for (int i = 0; i < N; i++) begin
      if (!any && req[i]) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        idx      = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/rdma_sq_arbiter.sv
// Shares one RDMA send queue and its ack return path between N_REQ user
// regions. Requesters that hold credit are granted in round-robin order.
// Each command is issued with its requester id. Each ack is routed back to
// the requester named in the ack word, and restores one credit to it.
//   aclk, areset           clock and asynchronous active-high reset
//   s_sq_valid/ready/data  per-requester command streams (packed by index)
//   m_sq_valid/ready/data  network-side command slot, m_sq_id = source
//   s_ack_valid/ready/data network-side ack stream
//   m_ack_valid/ready      per-requester ack handshake; m_ack_data is shared
//   credit_o               current credit per requester (packed by index)
//   err_o                  sticky: bad ack id, or ack to a requester at full credit
module rdma_sq_arbiter
  import lynxTypes::*;
#(
  parameter  int N_REQ      = 4,
  parameter  int SQ_BITS    = 256,
  parameter  int ACK_BITS   = 32,
  parameter  int ACK_ID_LSB = RDMA_ACK_ID_LSB,
  parameter  int N_CREDITS  = RDMA_N_CREDITS,
  localparam int ID_BITS    = id_width(N_REQ),
  localparam int CRED_BITS  = $clog2(N_CREDITS + 1)
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [N_REQ-1:0]             s_sq_valid,
  output logic [N_REQ-1:0]             s_sq_ready,
  input  logic [N_REQ*SQ_BITS-1:0]     s_sq_data,
  output logic                         m_sq_valid,
  input  logic                         m_sq_ready,
  output logic [SQ_BITS-1:0]           m_sq_data,
  output logic [ID_BITS-1:0]           m_sq_id,
  input  logic                         s_ack_valid,
  output logic                         s_ack_ready,
  input  logic [ACK_BITS-1:0]          s_ack_data,
  output logic [N_REQ-1:0]             m_ack_valid,
  input  logic [N_REQ-1:0]             m_ack_ready,
  output logic [ACK_BITS-1:0]          m_ack_data,
  output logic [N_REQ*CRED_BITS-1:0]   credit_o,
  output logic                         err_o
);

  localparam logic [CRED_BITS-1:0] CRED_MAX = CRED_BITS'(N_CREDITS);

  logic [CRED_BITS-1:0] credit [N_REQ];
  logic [ID_BITS-1:0]   rr_ptr;
  logic [N_REQ-1:0]     eligible, pick_req, grant, full_vec, ack_onehot;
  logic [ID_BITS-1:0]   grant_idx, ack_id;
  logic                 grant_any, slot_free, ack_hs, ack_err;
  logic [SQ_BITS-1:0]   grant_data;

  // ---------------- command side ----------------
  always_comb begin
    eligible = '0;
    full_vec = '0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = s_sq_valid[i] && (credit[i] != '0);
      full_vec[i] = (credit[i] == CRED_MAX);
    end
  end

  // Grant only into a free slot, and never while reset is asserted. A
  // request in that case leaves rr_ptr and the credits unchanged.
  assign slot_free = !m_sq_valid || m_sq_ready;
  assign pick_req  = (slot_free && !areset) ? eligible : '0;

  rdma_rr_pick #(.N(N_REQ)) u_pick (
    .req   (pick_req),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  assign s_sq_ready = grant;

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i]) grant_data = s_sq_data[i*SQ_BITS +: SQ_BITS];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the clock edge.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_sq_valid <= 1'b0;
      m_sq_data  <= '0;
      m_sq_id    <= '0;
      rr_ptr     <= '0;
    end else if (grant_any) begin
      m_sq_valid <= 1'b1;
      m_sq_data  <= grant_data;
      m_sq_id    <= grant_idx;
      rr_ptr     <= (grant_idx == ID_BITS'(N_REQ - 1)) ? '0 : grant_idx + ID_BITS'(1);
    end else if (m_sq_ready) begin
      m_sq_valid <= 1'b0;
    end
  end

  // ---------------- ack side ----------------
  assign ack_id = s_ack_data[ACK_ID_LSB +: ID_BITS];

  // The one-hot is all zero for an id >= N_REQ. Such an ack is consumed,
  // but it is not forwarded and it is not credited to anyone.
  always_comb begin
    ack_onehot = '0;
    for (int i = 0; i < N_REQ; i++)
      ack_onehot[i] = (ack_id == ID_BITS'(i));
  end

  // m_ack_valid is nonzero exactly while an ack is held, so the held id is
  // implicit in which of its bits is set.
  assign s_ack_ready = !(|m_ack_valid) || (|(m_ack_valid & m_ack_ready));
  assign ack_hs      = s_ack_valid && s_ack_ready;
  assign ack_err     = ack_hs && (!(|ack_onehot) || (|(ack_onehot & full_vec)));

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_ack_valid <= '0;
      m_ack_data  <= '0;
    end else if (ack_hs) begin
      m_ack_valid <= ack_onehot;
      if (|ack_onehot) m_ack_data <= s_ack_data;
    end else if (|(m_ack_valid & m_ack_ready)) begin
      m_ack_valid <= '0;
    end
  end

  // ---------------- credits and error ----------------
  // NOTE: the credit array is built from flops, not a RAM, so it can take
  // the asynchronous reset. This refills every credit as soon as reset
  // is asserted.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < N_REQ; i++) credit[i] <= CRED_MAX;
      err_o <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        // A grant and an ack in the same cycle cancel out.
        case ({grant[i], ack_hs && ack_onehot[i]})
          2'b10:   credit[i] <= credit[i] - CRED_BITS'(1);
          2'b01:   if (!full_vec[i]) credit[i] <= credit[i] + CRED_BITS'(1);
          default: ;
        endcase
      end
      if (ack_err) err_o <= 1'b1;
    end
  end

  always_comb begin
    credit_o = '0;
    for (int i = 0; i < N_REQ; i++)
      credit_o[i*CRED_BITS +: CRED_BITS] = credit[i];
  end

endmodule

// File: tb/tb_rdma_sq_arbiter.sv
// Directed bench for rdma_sq_arbiter. It uses two instances.
//   dut_a: N_REQ=4, N_CREDITS=2, ack id at bit 0
//   dut_b: N_REQ=3, N_CREDITS=8, ack id at bit 4, so that id 3 is a bad id
module tb_rdma_sq_arbiter;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  // dut_a signals
  logic [3:0]  a_sq_valid, a_sq_ready;
  logic [63:0] a_sq_data;
  logic        a_m_sq_valid, a_m_sq_ready;
  logic [15:0] a_m_sq_data;
  logic [1:0]  a_m_sq_id;
  logic        a_ack_valid, a_ack_ready;
  logic [7:0]  a_ack_data;
  logic [3:0]  a_m_ack_valid, a_m_ack_ready;
  logic [7:0]  a_m_ack_data;
  logic [7:0]  a_credit;
  logic        a_err;

  // dut_b signals
  logic [2:0]  b_sq_valid, b_sq_ready;
  logic [47:0] b_sq_data;
  logic        b_m_sq_valid, b_m_sq_ready;
  logic [15:0] b_m_sq_data;
  logic [1:0]  b_m_sq_id;
  logic        b_ack_valid, b_ack_ready;
  logic [7:0]  b_ack_data;
  logic [2:0]  b_m_ack_valid, b_m_ack_ready;
  logic [7:0]  b_m_ack_data;
  logic [11:0] b_credit;
  logic        b_err;

  int n_checks = 0;
  int n_pass   = 0;

  rdma_sq_arbiter #(.N_REQ(4), .SQ_BITS(16), .ACK_BITS(8), .ACK_ID_LSB(0), .N_CREDITS(2)) dut_a (
    .aclk(aclk), .areset(areset),
    .s_sq_valid(a_sq_valid), .s_sq_ready(a_sq_ready), .s_sq_data(a_sq_data),
    .m_sq_valid(a_m_sq_valid), .m_sq_ready(a_m_sq_ready), .m_sq_data(a_m_sq_data), .m_sq_id(a_m_sq_id),
    .s_ack_valid(a_ack_valid), .s_ack_ready(a_ack_ready), .s_ack_data(a_ack_data),
    .m_ack_valid(a_m_ack_valid), .m_ack_ready(a_m_ack_ready), .m_ack_data(a_m_ack_data),
    .credit_o(a_credit), .err_o(a_err)
  );

  rdma_sq_arbiter #(.N_REQ(3), .SQ_BITS(16), .ACK_BITS(8), .ACK_ID_LSB(4), .N_CREDITS(8)) dut_b (
    .aclk(aclk), .areset(areset),
    .s_sq_valid(b_sq_valid), .s_sq_ready(b_sq_ready), .s_sq_data(b_sq_data),
    .m_sq_valid(b_m_sq_valid), .m_sq_ready(b_m_sq_ready), .m_sq_data(b_m_sq_data), .m_sq_id(b_m_sq_id),
    .s_ack_valid(b_ack_valid), .s_ack_ready(b_ack_ready), .s_ack_data(b_ack_data),
    .m_ack_valid(b_m_ack_valid), .m_ack_ready(b_m_ack_ready), .m_ack_data(b_m_ack_data),
    .credit_o(b_credit), .err_o(b_err)
  );

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_inputs();
    a_sq_valid = '0; a_sq_data = '0; a_m_sq_ready = 1'b0;
    a_ack_valid = 1'b0; a_ack_data = '0; a_m_ack_ready = '0;
    b_sq_valid = '0; b_sq_data = '0; b_m_sq_ready = 1'b0;
    b_ack_valid = 1'b0; b_ack_data = '0; b_m_ack_ready = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    areset = 1'b1;
    step();
    areset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    areset = 1'b1;
    #3;
    n_checks++; if (a_m_sq_valid !== 1'b0) $display("FAIL rst_m_sq_valid got %b exp 0", a_m_sq_valid); else n_pass++;
    n_checks++; if (a_sq_ready !== 4'b0000) $display("FAIL rst_s_sq_ready got %b exp 0000", a_sq_ready); else n_pass++;
    n_checks++; if (a_ack_ready !== 1'b1) $display("FAIL rst_s_ack_ready got %b exp 1", a_ack_ready); else n_pass++;
    n_checks++; if (a_m_ack_valid !== 4'b0000) $display("FAIL rst_m_ack_valid got %b exp 0000", a_m_ack_valid); else n_pass++;
    n_checks++; if (a_m_sq_data !== 16'h0) $display("FAIL rst_m_sq_data got %h exp 0000", a_m_sq_data); else n_pass++;
    n_checks++; if (a_m_sq_id !== 2'd0) $display("FAIL rst_m_sq_id got %0d exp 0", a_m_sq_id); else n_pass++;
    n_checks++; if (a_m_ack_data !== 8'h0) $display("FAIL rst_m_ack_data got %h exp 00", a_m_ack_data); else n_pass++;
    n_checks++; if (a_credit !== 8'hAA) $display("FAIL rst_credit_a got %h exp aa", a_credit); else n_pass++;
    n_checks++; if (b_credit !== 12'h888) $display("FAIL rst_credit_b got %h exp 888", b_credit); else n_pass++;
    n_checks++; if (a_err !== 1'b0) $display("FAIL rst_err got %b exp 0", a_err); else n_pass++;
    step();
    areset = 1'b0;
    #1;
  endtask

  // All four valid with two credits each: ids 0,1,2,3,0,1,2,3, then stop.
  task automatic test_round_robin();
    do_reset();
    a_sq_data    = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    a_sq_valid   = 4'b1111;
    a_m_sq_ready = 1'b1;
    #1;
    n_checks++; if (a_sq_ready !== 4'b0001) $display("FAIL rr_first_ready got %b exp 0001", a_sq_ready); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      logic [3:0] exp_rdy;
      exp_rdy = (k < 7) ? 4'(1 << ((k + 1) % 4)) : 4'b0000;
      step();
      n_checks++; if (a_m_sq_valid !== 1'b1) $display("FAIL rr_valid k=%0d got %b exp 1", k, a_m_sq_valid); else n_pass++;
      n_checks++; if (a_m_sq_id !== 2'(k % 4)) $display("FAIL rr_id k=%0d got %0d exp %0d", k, a_m_sq_id, k % 4); else n_pass++;
      n_checks++; if (a_m_sq_data !== 16'(16'h1000 + k % 4)) $display("FAIL rr_data k=%0d got %h exp %h", k, a_m_sq_data, 16'(16'h1000 + k % 4)); else n_pass++;
      n_checks++; if (a_sq_ready !== exp_rdy) $display("FAIL rr_ready k=%0d got %b exp %b", k, a_sq_ready, exp_rdy); else n_pass++;
    end
    step();
    n_checks++; if (a_m_sq_valid !== 1'b0) $display("FAIL rr_drained got %b exp 0", a_m_sq_valid); else n_pass++;
    n_checks++; if (a_credit !== 8'h00) $display("FAIL rr_credit got %h exp 00", a_credit); else n_pass++;
  endtask

  task automatic test_credit_exhaustion();
    do_reset();
    a_sq_data    = {16'h0, 16'h0, 16'hBEE1, 16'h0};
    a_sq_valid   = 4'b0010;
    a_m_sq_ready = 1'b1;
    step();
    step();
    n_checks++; if (a_sq_ready !== 4'b0000) $display("FAIL ex_ready_zero got %b exp 0000", a_sq_ready); else n_pass++;
    step();
    n_checks++; if (a_m_sq_valid !== 1'b0) $display("FAIL ex_third_blocked got %b exp 0", a_m_sq_valid); else n_pass++;
    n_checks++; if (a_credit !== 8'hA2) $display("FAIL ex_credit_zero got %h exp a2", a_credit); else n_pass++;
    a_ack_valid   = 1'b1;
    a_ack_data    = 8'h51;
    a_m_ack_ready = 4'b1111;
    #1;
    n_checks++; if (a_ack_ready !== 1'b1) $display("FAIL ex_ack_ready got %b exp 1", a_ack_ready); else n_pass++;
    step();
    a_ack_valid = 1'b0;
    #1;
    n_checks++; if (a_m_ack_valid !== 4'b0010) $display("FAIL ex_ack_route got %b exp 0010", a_m_ack_valid); else n_pass++;
    n_checks++; if (a_m_ack_data !== 8'h51) $display("FAIL ex_ack_data got %h exp 51", a_m_ack_data); else n_pass++;
    n_checks++; if (a_credit !== 8'hA6) $display("FAIL ex_credit_back got %h exp a6", a_credit); else n_pass++;
    n_checks++; if (a_sq_ready !== 4'b0010) $display("FAIL ex_eligible_again got %b exp 0010", a_sq_ready); else n_pass++;
    n_checks++; if (a_m_sq_valid !== 1'b0) $display("FAIL ex_not_yet got %b exp 0", a_m_sq_valid); else n_pass++;
    step();
    n_checks++; if (a_m_sq_valid !== 1'b1 || a_m_sq_id !== 2'd1) $display("FAIL ex_third_issue got v=%b id=%0d exp v=1 id=1", a_m_sq_valid, a_m_sq_id); else n_pass++;
    n_checks++; if (a_m_ack_valid !== 4'b0000) $display("FAIL ex_ack_cleared got %b exp 0000", a_m_ack_valid); else n_pass++;
    n_checks++; if (a_credit !== 8'hA2) $display("FAIL ex_credit_final got %h exp a2", a_credit); else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    a_sq_data    = {16'h0D03, 16'h0D02, 16'h0D01, 16'h00A5};
    a_sq_valid   = 4'b0001;
    a_m_sq_ready = 1'b1;
    step();
    a_m_sq_ready = 1'b0;
    a_sq_valid   = 4'b1111;
    #1;
    n_checks++; if (a_sq_ready !== 4'b0000) $display("FAIL bp_no_ready got %b exp 0000", a_sq_ready); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++; if (a_m_sq_valid !== 1'b1 || a_m_sq_data !== 16'h00A5 || a_m_sq_id !== 2'd0)
        $display("FAIL bp_hold k=%0d got v=%b d=%h id=%0d exp v=1 d=00a5 id=0", k, a_m_sq_valid, a_m_sq_data, a_m_sq_id);
      else n_pass++;
      n_checks++; if (a_sq_ready !== 4'b0000) $display("FAIL bp_ready k=%0d got %b exp 0000", k, a_sq_ready); else n_pass++;
      n_checks++; if (a_credit !== 8'hA9) $display("FAIL bp_credit k=%0d got %h exp a9", k, a_credit); else n_pass++;
    end
    a_m_sq_ready = 1'b1;
    #1;
    n_checks++; if (a_sq_ready !== 4'b0010) $display("FAIL bp_release got %b exp 0010", a_sq_ready); else n_pass++;
    a_sq_valid = '0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    a_sq_data    = {16'h0, 16'h2222, 16'h0, 16'h0};
    a_sq_valid   = 4'b0100;
    a_m_sq_ready = 1'b1;
    step();
    a_ack_valid   = 1'b1;
    a_ack_data    = 8'h02;
    a_m_ack_ready = 4'b1111;
    #1;
    n_checks++; if (a_sq_ready !== 4'b0100 || a_ack_ready !== 1'b1) $display("FAIL sim_both_ready got sq=%b ack=%b exp sq=0100 ack=1", a_sq_ready, a_ack_ready); else n_pass++;
    step();
    a_ack_valid = 1'b0;
    a_sq_valid  = '0;
    #1;
    n_checks++; if (a_credit !== 8'h9A) $display("FAIL sim_credit got %h exp 9a", a_credit); else n_pass++;
    n_checks++; if (a_m_ack_valid !== 4'b0100) $display("FAIL sim_ack_route got %b exp 0100", a_m_ack_valid); else n_pass++;
    n_checks++; if (a_m_sq_id !== 2'd2 || a_m_sq_data !== 16'h2222) $display("FAIL sim_sq got id=%0d d=%h exp id=2 d=2222", a_m_sq_id, a_m_sq_data); else n_pass++;
    n_checks++; if (a_err !== 1'b0) $display("FAIL sim_err got %b exp 0", a_err); else n_pass++;
  endtask

  task automatic test_full_ack();
    do_reset();
    a_ack_valid   = 1'b1;
    a_ack_data    = 8'h00;
    a_m_ack_ready = 4'b0000;
    step();
    a_ack_valid = 1'b0;
    #1;
    n_checks++; if (a_err !== 1'b1) $display("FAIL full_err got %b exp 1", a_err); else n_pass++;
    n_checks++; if (a_m_ack_valid !== 4'b0001) $display("FAIL full_forward got %b exp 0001", a_m_ack_valid); else n_pass++;
    n_checks++; if (a_credit !== 8'hAA) $display("FAIL full_saturate got %h exp aa", a_credit); else n_pass++;
    n_checks++; if (a_ack_ready !== 1'b0) $display("FAIL full_held_blocks got %b exp 0", a_ack_ready); else n_pass++;
    a_m_ack_ready = 4'b0001;
    step();
    n_checks++; if (a_m_ack_valid !== 4'b0000 || a_err !== 1'b1) $display("FAIL full_after got v=%b err=%b exp v=0000 err=1", a_m_ack_valid, a_err); else n_pass++;
  endtask

  task automatic test_bad_ack();
    do_reset();
    b_ack_valid   = 1'b1;
    b_ack_data    = 8'h30;
    b_m_ack_ready = 3'b111;
    #1;
    n_checks++; if (b_ack_ready !== 1'b1) $display("FAIL bad_ready got %b exp 1", b_ack_ready); else n_pass++;
    step();
    b_ack_valid = 1'b0;
    #1;
    n_checks++; if (b_m_ack_valid !== 3'b000) $display("FAIL bad_not_fwd got %b exp 000", b_m_ack_valid); else n_pass++;
    n_checks++; if (b_err !== 1'b1) $display("FAIL bad_err got %b exp 1", b_err); else n_pass++;
    n_checks++; if (b_credit !== 12'h888) $display("FAIL bad_credit got %h exp 888", b_credit); else n_pass++;
    repeat (3) step();
    n_checks++; if (b_err !== 1'b1) $display("FAIL bad_err_sticky got %b exp 1", b_err); else n_pass++;
    do_reset();
    n_checks++; if (b_err !== 1'b0) $display("FAIL bad_err_cleared got %b exp 0", b_err); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    b_sq_data    = {16'h0, 16'h0, 16'hC0DE};
    b_sq_valid   = 3'b001;
    b_m_sq_ready = 1'b1;
    repeat (3) step();
    n_checks++; if (b_credit !== 12'h885) $display("FAIL mid_credit_pre got %h exp 885", b_credit); else n_pass++;
    n_checks++; if (b_m_sq_valid !== 1'b1) $display("FAIL mid_valid_pre got %b exp 1", b_m_sq_valid); else n_pass++;
    #2;
    areset = 1'b1;
    #1;
    n_checks++; if (b_m_sq_valid !== 1'b0) $display("FAIL mid_valid_async got %b exp 0", b_m_sq_valid); else n_pass++;
    n_checks++; if (b_credit !== 12'h888) $display("FAIL mid_credit_async got %h exp 888", b_credit); else n_pass++;
    n_checks++; if (b_sq_ready !== 3'b000) $display("FAIL mid_ready_in_reset got %b exp 000", b_sq_ready); else n_pass++;
    b_sq_valid = 3'b111;
    @(negedge aclk);
    areset = 1'b0;
    #1;
    n_checks++; if (b_sq_ready !== 3'b001) $display("FAIL mid_first_ready got %b exp 001", b_sq_ready); else n_pass++;
    step();
    n_checks++; if (b_m_sq_valid !== 1'b1 || b_m_sq_id !== 2'd0) $display("FAIL mid_first_grant got v=%b id=%0d exp v=1 id=0", b_m_sq_valid, b_m_sq_id); else n_pass++;
    b_sq_valid = '0;
  endtask

  initial begin
    clear_inputs();
    areset = 1'b0;
    test_reset();
    test_round_robin();
    test_credit_exhaustion();
    test_backpressure();
    test_simultaneous();
    test_full_ack();
    test_bad_ack();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rdma_sq_arbiter.md
# rdma_sq_arbiter

- Shares one RDMA send queue and its ack return path between N_REQ user regions.
- Round-robin grant among requesters that have outstanding-command credit. Issued commands are tagged with the requester id, and acks are routed back to their requester.
- Each returned ack restores one credit to that requester.
- Sits between the per-region user SQ/ack streams and the network-side SQ/ack FIFOs.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..16); ID_BITS = clog2(N_REQ), minimum 1.
- SQ_BITS, 256, SQ command width.
- ACK_BITS, 32, ack word width.
- ACK_ID_LSB, 0, LSB of the requester-id field inside the ack word.
- N_CREDITS, 16, maximum outstanding commands per requester; CRED_BITS = clog2(N_CREDITS+1).

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  asynchronous, active-high reset.
- s_sq_valid  in  N_REQ  per-requester command valid.
- s_sq_ready  out  N_REQ  per-requester command ready.
- s_sq_data  in  N_REQ*SQ_BITS  commands; requester i occupies [i*SQ_BITS +: SQ_BITS].
- m_sq_valid  out  1  network SQ valid.
- m_sq_ready  in  1  network SQ ready.
- m_sq_data  out  SQ_BITS  granted command.
- m_sq_id  out  ID_BITS  requester id of m_sq_data.
- s_ack_valid  in  1  network ack valid.
- s_ack_ready  out  1  network ack ready.
- s_ack_data  in  ACK_BITS  ack word; requester id at [ACK_ID_LSB +: ID_BITS].
- m_ack_valid  out  N_REQ  per-requester ack valid.
- m_ack_ready  in  N_REQ  per-requester ack ready.
- m_ack_data  out  ACK_BITS  registered ack word, shared by all requesters.
- credit_o  out  N_REQ*CRED_BITS  current credit per requester.
- err_o  out  1  sticky error: ack id ≥ N_REQ, or ack to a requester already at N_CREDITS.

## Operation
- **Eligibility:** requester i is eligible when s_sq_valid[i]=1 and credit[i]>0.
- **Grant:** the first eligible index at or after rr_ptr, modulo N_REQ.
  - A grant occurs only when the output slot is free: !m_sq_valid, or m_sq_valid && m_sq_ready.
  - s_sq_ready[i] = 1 only for the granted index in that cycle; at most one bit is set.
- **On grant g:**
  - Slot loads s_sq_data[g] and id g; m_sq_valid=1.
  - rr_ptr = (g+1) mod N_REQ.
  - credit[g] decrements.
- **No grant** (nothing eligible, or slot blocked): rr_ptr and credits hold.
- **Ack path:** one-entry register.
  - s_ack_ready = !ack_held || m_ack_ready[ack_id_reg].
  - On s_ack handshake: load word and id; credit[id] increments; m_ack_valid[id]=1.
- **Bad ack id (≥ N_REQ):** ack is accepted, credited to nobody, not forwarded, and err_o is set.
- **Ack to a full requester** (credit already N_CREDITS): credit saturates, ack is still forwarded, err_o is set.
- **Same-cycle grant and ack on one requester:** credit is unchanged (−1 and +1).
- err_o clears only on reset.

## Timing
- **Reset values:** m_sq_valid=0, s_sq_ready=0, s_ack_ready=1, m_ack_valid=0, m_sq_data=0, m_ack_data=0, m_sq_id=0, rr_ptr=0, every credit=N_CREDITS, err_o=0.
- **Command latency:** 1 cycle from the s_sq handshake to m_sq_valid.
- **Command throughput:** full rate of one command per cycle while m_sq_ready=1.
- **Ack latency:** 1 cycle from the s_ack handshake to m_ack_valid. Full rate while the target requester is ready.
- **Handshake stability:** m_sq_data and m_sq_id are stable while m_sq_valid && !m_sq_ready; m_ack_data is stable likewise.
- s_sq_ready depends combinationally on s_sq_valid, credit, rr_ptr and m_sq_ready. No combinational path exists from s_ack to any m_sq signal.
- **Credit exhaustion:** a requester at credit 0 is skipped even when valid. It is eligible again in the cycle after its ack handshake.
- **Reset mid-operation:** held commands and acks are discarded; credits return to N_CREDITS immediately on assertion (asynchronous).

## Structure
- Shared constants belong in lynxTypes: RDMA_ACK_ID_LSB and RDMA_N_CREDITS defaults, so queue and arbiter agree on the ack format.
- One sub-module, rdma_rr_pick:
  - Combinational round-robin search.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and binary index.
  - Reusable for other shared queues (rd/wr request paths).
- Credit counters, the SQ slot, the ack register and err_o stay in rdma_sq_arbiter.

## Test plan
- **Round-robin order:** all 4 requesters valid, m_sq_ready=1 → m_sq_id sequence 0,1,2,3,0,… with one command per cycle, starting at the second cycle.
- **Credit exhaustion:** N_CREDITS=2, requester 1 alone sends 3 commands, no acks → only 2 issued and credit_o[1]=0. Ack with id 1 → third issued 2 cycles after the ack handshake.
- **Backpressure:** m_sq_ready=0 for 5 cycles with data 0xA5 held → m_sq_data stable at 0xA5, no s_sq_ready asserted, no credit change.
- **Simultaneous grant and ack:** requester 2 is granted in the same cycle an ack for id 2 is accepted → credit_o[2] unchanged.
- **Bad ack id:** N_REQ=3, ack id 3 → s_ack_ready=1, no m_ack_valid, err_o=1 until reset.
- **Reset mid-operation:** areset asserted with m_sq_valid=1 and credits at 5 → m_sq_valid=0 and all credits=N_CREDITS in the same cycle; first grant after release goes to requester 0.
